// File: rtl/tspi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tspi_xfer_ctrl
//
// Transaction sequencer that sits directly upstream of the TSPI shift register.
// It takes one command/response request, generates the TSPI serial clock and
// drives the shift stage's load/write controls. It then waits for the device
// start bit and counts the response bits. The captured response is returned
// together with a timeout flag.
//
// Parameters
//   HALF_DIV      clk_i cycles per TSPI clock half-period (>= 2)
//   TIMEOUT_RISE  TSPI rising edges to wait for a start bit before aborting (>= 1)
//
// Ports
//   clk_i          system clock, single domain
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request valid
//   req_ready_o    request ready, high only while idle
//   req_cmd_i      command word, MSB-first, MSB-aligned
//   req_cmd_len_i  command bits minus 1 (0..31)
//   req_rsp_len_i  response bits minus 1 (0..31)
//   rsp_valid_o    response valid
//   rsp_ready_i    response ready
//   rsp_data_o     response, LSB-aligned, unused upper bits zero
//   rsp_timeout_o  no start bit was seen; rsp_data_o is zero
//   busy_o         transfer in progress or response pending
//   tspi_clk_o     TSPI clock to pad and shift stage, idles low
//   len_cmd_o      latched command length to the shift stage
//   new_cmd_o      load strobe for the command word
//   en_write_o     drive command bits on MOSI
//   cmd_data_o     latched command word to the shift stage
//   start_bit_i    start bit detected by the shift stage
//   shift_data_i   shift register contents
//
// States
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | clock stopped, ready for a request
//   ST_CMD      | clocking command bits out, en_write_o high
//   ST_WAIT     | clocking while looking for the device start bit
//   ST_RSP      | clocking response bits into the shift stage
//   ST_DONE     | clock stopped, response held until rsp_ready_i
// -----------------------------------------------------------------------------
module tspi_xfer_ctrl #(
    parameter int HALF_DIV     = 4,
    parameter int TIMEOUT_RISE = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_cmd_i,
    input  logic [5:0]  req_cmd_len_i,
    input  logic [5:0]  req_rsp_len_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,

    output logic        busy_o,

    output logic        tspi_clk_o,
    output logic [5:0]  len_cmd_o,
    output logic        new_cmd_o,
    output logic        en_write_o,
    output logic [31:0] cmd_data_o,
    input  logic        start_bit_i,
    input  logic [31:0] shift_data_i
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RSP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_RISE + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_RISE);
    localparam logic [5:0]       BIT_MAX  = 6'd32;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             tspi_clk;
    logic [5:0]       bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [5:0]       cmd_len;
    logic [5:0]       rsp_len;
    logic [31:0]      cmd_data;
    logic             new_cmd;
    logic             en_write;
    logic [31:0]      rsp_data;
    logic             rsp_timeout;

    logic             clk_run;
    logic             div_tc;
    logic             rise_evt;
    logic             fall_evt;
    logic [5:0]       bit_cnt_inc;
    logic             cmd_last;
    logic             rsp_last;
    logic             to_expired;
    logic [32:0]      rsp_mask;
    logic [31:0]      rsp_capture;

    // ------------------------------------------------------------------
    // Event strobes. rise_evt/fall_evt are high in the clk_i cycle whose
    // closing edge moves tspi_clk, so anything updated on fall_evt changes
    // together with the falling TSPI edge and is stable across every rise.
    // ------------------------------------------------------------------
    always_comb begin
        clk_run  = (state == ST_CMD) || (state == ST_WAIT) || (state == ST_RSP);
        div_tc   = clk_run && (div_cnt == '0);
        rise_evt = div_tc && !tspi_clk;
        fall_evt = div_tc && tspi_clk;
    end

    // Bit counters saturate at 32 so an over-long run can never wrap
    // back onto a valid terminal count.
    always_comb begin
        bit_cnt_inc = (bit_cnt == BIT_MAX) ? bit_cnt : (bit_cnt + 6'd1);
        cmd_last    = (bit_cnt == (cmd_len + 6'd1));
        rsp_last    = (bit_cnt == (rsp_len + 6'd1));
        to_expired  = (to_cnt == TO_LIMIT);
    end

    // The mask is built in 33 bits so a 32-bit response yields all ones.
    always_comb begin
        rsp_mask    = (33'd1 << (rsp_len + 6'd1)) - 33'd1;
        rsp_capture = shift_data_i & rsp_mask[31:0];
    end

    // ------------------------------------------------------------------
    // TSPI clock divider: down-counter reloaded with HALF_DIV-1, the clock
    // toggles on terminal count. Leaving IDLE always starts a full low
    // phase because the counter is preloaded while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt  <= DIV_LOAD;
            tspi_clk <= 1'b0;
        end else if (clk_run) begin
            if (div_cnt == '0) begin
                div_cnt  <= DIV_LOAD;
                tspi_clk <= ~tspi_clk;
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end else begin
            div_cnt  <= DIV_LOAD;
            tspi_clk <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            cmd_len     <= '0;
            rsp_len     <= '0;
            cmd_data    <= '0;
            new_cmd     <= 1'b0;
            en_write    <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        // Lengths are 0..31; the top bit is dropped so a
                        // stray value cannot push a terminal count past 32.
                        cmd_data <= req_cmd_i;
                        cmd_len  <= {1'b0, req_cmd_len_i[4:0]};
                        rsp_len  <= {1'b0, req_rsp_len_i[4:0]};
                        new_cmd  <= 1'b1;
                        en_write <= 1'b1;
                        bit_cnt  <= '0;
                        to_cnt   <= '0;
                        state    <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (rise_evt) begin
                        bit_cnt <= bit_cnt_inc;
                    end
                    if (fall_evt) begin
                        new_cmd <= 1'b0;
                        if (cmd_last) begin
                            en_write <= 1'b0;
                            bit_cnt  <= '0;
                            to_cnt   <= '0;
                            state    <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (rise_evt) begin
                        if (start_bit_i) begin
                            // The start-bit rise is not a data bit.
                            bit_cnt <= '0;
                            state   <= ST_RSP;
                        end else if (!to_expired) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    // Abort on the fall so the clock parks low in DONE.
                    if (fall_evt && to_expired) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end
                end

                ST_RSP: begin
                    if (rise_evt) begin
                        bit_cnt <= bit_cnt_inc;
                    end
                    if (fall_evt && rsp_last) begin
                        rsp_data    <= rsp_capture;
                        rsp_timeout <= 1'b0;
                        state       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o   = (state == ST_IDLE);
        busy_o        = (state != ST_IDLE);
        rsp_valid_o   = (state == ST_DONE);
        rsp_data_o    = rsp_data;
        rsp_timeout_o = rsp_timeout;
        tspi_clk_o    = tspi_clk;
        len_cmd_o     = cmd_len;
        new_cmd_o     = new_cmd;
        en_write_o    = en_write;
        cmd_data_o    = cmd_data;
    end

endmodule

// File: tb/tb_tspi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tspi_xfer_ctrl
//
// Bench for tspi_xfer_ctrl. A behavioural device model answers the TSPI
// clock: after a chosen number of rises in the wait phase it raises the start
// bit, then shifts response bits MSB-first into a shift register that starts
// out with random contents. Expected results come from the request fields:
// command rises = cmd_len+1, response = value masked to rsp_len+1 bits, or
// timeout when the start bit is later than TIMEOUT_RISE rises. Two extra
// instances with HALF_DIV 2 and 7 run free to check clock phase lengths.
// -----------------------------------------------------------------------------
module tb_tspi_xfer_ctrl;

    localparam int HD = 4;
    localparam int TO = 64;
    localparam int WAIT_BUDGET = 6000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_cmd;
    logic [5:0]  req_cmd_len;
    logic [5:0]  req_rsp_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        tspi_clk;
    logic [5:0]  len_cmd;
    logic        new_cmd;
    logic        en_write;
    logic [31:0] cmd_data;
    logic        start_bit;
    logic [31:0] shift_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    tspi_xfer_ctrl #(.HALF_DIV(HD), .TIMEOUT_RISE(TO)) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_cmd_i     (req_cmd),
        .req_cmd_len_i (req_cmd_len),
        .req_rsp_len_i (req_rsp_len),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_timeout_o (rsp_timeout),
        .busy_o        (busy),
        .tspi_clk_o    (tspi_clk),
        .len_cmd_o     (len_cmd),
        .new_cmd_o     (new_cmd),
        .en_write_o    (en_write),
        .cmd_data_o    (cmd_data),
        .start_bit_i   (start_bit),
        .shift_data_i  (shift_data)
    );

    // Free-running instances for other divider settings: they loop through
    // request -> timeout -> response handshake forever.
    logic        tclk_a [3];
    logic        busy_a [3];
    logic        new_a  [3];
    logic        en_a   [3];
    logic [5:0]  len_a  [3];
    logic [31:0] cd_a   [3];
    logic        rdy_x  [3];
    logic        vld_x  [3];
    logic [31:0] dat_x  [3];
    logic        to_x   [3];

    assign tclk_a[0] = tspi_clk;
    assign busy_a[0] = busy;
    assign new_a[0]  = new_cmd;
    assign en_a[0]   = en_write;
    assign len_a[0]  = len_cmd;
    assign cd_a[0]   = cmd_data;
    assign rdy_x[0]  = req_ready;
    assign vld_x[0]  = rsp_valid;
    assign dat_x[0]  = rsp_data;
    assign to_x[0]   = rsp_timeout;

    tspi_xfer_ctrl #(.HALF_DIV(2), .TIMEOUT_RISE(2)) u_hd2 (
        .clk_i (clk), .rst_ni (rst_n),
        .req_valid_i (rdy_x[1]), .req_ready_o (rdy_x[1]),
        .req_cmd_i (32'h5A5A_0F0F), .req_cmd_len_i (6'd3), .req_rsp_len_i (6'd3),
        .rsp_valid_o (vld_x[1]), .rsp_ready_i (vld_x[1]),
        .rsp_data_o (dat_x[1]), .rsp_timeout_o (to_x[1]), .busy_o (busy_a[1]),
        .tspi_clk_o (tclk_a[1]), .len_cmd_o (len_a[1]), .new_cmd_o (new_a[1]),
        .en_write_o (en_a[1]), .cmd_data_o (cd_a[1]),
        .start_bit_i (1'b0), .shift_data_i (32'hFFFF_FFFF)
    );

    tspi_xfer_ctrl #(.HALF_DIV(7), .TIMEOUT_RISE(2)) u_hd7 (
        .clk_i (clk), .rst_ni (rst_n),
        .req_valid_i (rdy_x[2]), .req_ready_o (rdy_x[2]),
        .req_cmd_i (32'h5A5A_0F0F), .req_cmd_len_i (6'd3), .req_rsp_len_i (6'd3),
        .rsp_valid_o (vld_x[2]), .rsp_ready_i (vld_x[2]),
        .rsp_data_o (dat_x[2]), .rsp_timeout_o (to_x[2]), .busy_o (busy_a[2]),
        .tspi_clk_o (tclk_a[2]), .len_cmd_o (len_a[2]), .new_cmd_o (new_a[2]),
        .en_write_o (en_a[2]), .cmd_data_o (cd_a[2]),
        .start_bit_i (1'b0), .shift_data_i (32'hFFFF_FFFF)
    );

    // Free-running instances never see a start bit, so every response
    // they produce must be a timeout with zero data.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 1; k < 3; k++) begin
                if (vld_x[k]) begin
                    chk("free_timeout_flag", 64'(to_x[k]), 64'(1));
                    chk("free_timeout_data", 64'(dat_x[k]), 64'(0));
                end
            end
        end
    end

    // Clock phase lengths and control stability across rises, per instance.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int HDG = (g == 0) ? HD : ((g == 1) ? 2 : 7);
        logic        prev_t;
        logic [38:0] prev_ctl;
        logic [38:0] ctl;
        int          hi_cnt;
        int          lo_cnt;

        assign ctl = {new_a[g], en_a[g], len_a[g], cd_a[g]};

        always @(negedge clk) begin
            if (!rst_n) begin
                hi_cnt = 0;
                lo_cnt = 0;
                prev_t = 1'b0;
            end else begin
                if (!prev_t && tclk_a[g]) begin
                    chk("ctl_stable_at_rise", 64'(ctl), 64'(prev_ctl));
                    chk("low_phase_len", 64'(lo_cnt), 64'(HDG));
                end
                if (prev_t && !tclk_a[g] && busy_a[g]) begin
                    chk("high_phase_len", 64'(hi_cnt), 64'(HDG));
                end
                if (tclk_a[g]) begin
                    hi_cnt++;
                    lo_cnt = 0;
                end else begin
                    hi_cnt = 0;
                    lo_cnt = busy_a[g] ? lo_cnt + 1 : 0;
                end
                prev_t = tclk_a[g];
            end
            prev_ctl = ctl;
        end
    end

    // ------------------------------------------------------------------
    // Device model for the main instance.
    //   mode 0: command phase (start bit is random noise, must be ignored)
    //   mode 1: waiting; start bit raised before rise number dev_d+1
    //   mode 2: response; one bit of dev_rv shifted in per rise
    // ------------------------------------------------------------------
    int          dev_d  = 0;
    logic [31:0] dev_rv = '0;
    logic [5:0]  dev_rl = '0;
    int          mode;
    int          cmd_rises;
    int          new_rises;
    int          wait_rises;
    int          bits;
    logic        prev_t0 = 1'b0;
    logic        prev_en = 1'b0;
    logic        rise;

    initial begin
        start_bit  = 1'b0;
        shift_data = '0;
    end

    always @(negedge clk) begin
        rise = !prev_t0 && tspi_clk;
        if (!rst_n || !busy) begin
            mode       = 0;
            cmd_rises  = 0;
            new_rises  = 0;
            wait_rises = 0;
            bits       = 0;
            start_bit  = 1'b0;
            shift_data = $urandom;
        end else begin
            case (mode)
                0: begin
                    if (rise && en_write) cmd_rises++;
                    if (rise && new_cmd)  new_rises++;
                    if (prev_en && !en_write) begin
                        mode       = 1;
                        wait_rises = 0;
                        start_bit  = (dev_d == 0);
                    end else begin
                        start_bit = 1'($urandom);
                    end
                end
                1: begin
                    if (rise) begin
                        if (start_bit) begin
                            mode      = 2;
                            bits      = 0;
                            start_bit = 1'($urandom);
                        end else begin
                            wait_rises++;
                            start_bit = (wait_rises == dev_d);
                        end
                    end
                end
                default: begin
                    if (rise && bits <= int'(dev_rl)) begin
                        shift_data = {shift_data[30:0], dev_rv[int'(dev_rl) - bits]};
                        bits++;
                    end
                    start_bit = 1'($urandom);
                end
            endcase
        end
        prev_t0 = tspi_clk;
        prev_en = en_write;
    end

    // ------------------------------------------------------------------
    // One complete transaction. Called at a negedge with the DUT idle;
    // returns at a negedge with the DUT idle again.
    // ------------------------------------------------------------------
    task automatic run_xfer(input logic [31:0] cmd, input logic [5:0] cl,
                            input logic [5:0] rl, input logic [31:0] rv,
                            input int d, input int hold);
        logic [63:0] m;
        logic [31:0] exp_data;
        logic        exp_to;
        int          waited;
        exp_to   = (d >= TO);
        m        = (64'd1 << (int'(rl) + 1)) - 64'd1;
        exp_data = exp_to ? 32'd0 : (rv & m[31:0]);

        dev_d  = d;
        dev_rv = rv;
        dev_rl = rl;

        req_cmd     = cmd;
        req_cmd_len = cl;
        req_rsp_len = rl;
        req_valid   = 1'b1;
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid   = 1'b0;
        req_cmd     = $urandom;
        req_cmd_len = 6'($urandom);
        req_rsp_len = 6'($urandom);
        chk("busy_after_accept", 64'(busy), 64'(1));
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        chk("new_cmd_entry", 64'(new_cmd), 64'(1));
        chk("en_write_entry", 64'(en_write), 64'(1));
        chk("cmd_data_latched", 64'(cmd_data), 64'(cmd));
        chk("len_cmd_latched", 64'(len_cmd), 64'(cl));

        waited = 0;
        while (!rsp_valid && waited < WAIT_BUDGET) begin
            @(negedge clk);
            waited++;
        end
        chk("rsp_within_budget", 64'(waited < WAIT_BUDGET), 64'(1));

        chk("rsp_data", 64'(rsp_data), 64'(exp_data));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        chk("done_tclk_low", 64'(tspi_clk), 64'(0));
        chk("cmd_rise_count", 64'(cmd_rises), 64'(int'(cl) + 1));
        chk("new_cmd_rise_count", 64'(new_rises), 64'(1));
        if (exp_to) begin
            chk("timeout_rise_count", 64'(wait_rises), 64'(TO));
        end else begin
            chk("start_delay_rises", 64'(wait_rises), 64'(d));
            chk("rsp_bit_count", 64'(bits), 64'(int'(rl) + 1));
        end

        // Response held while ready is low; requests meanwhile are ignored.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_cmd   = $urandom;
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_data", 64'(rsp_data), 64'(exp_data));
            chk("hold_timeout", 64'(rsp_timeout), 64'(exp_to));
            chk("hold_tclk", 64'(tspi_clk), 64'(0));
            chk("hold_req_ready", 64'(req_ready), 64'(0));
        end

        // A request presented in the handshake cycle must not be taken.
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_cleared", 64'(rsp_valid), 64'(0));
        chk("timeout_cleared", 64'(rsp_timeout), 64'(0));
        chk("idle_after_hs", 64'(busy), 64'(0));
        chk("req_ready_after_hs", 64'(req_ready), 64'(1));
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        int waited;
        logic [5:0] cl;
        logic [5:0] rl;
        int d;

        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        req_cmd     = '0;
        req_cmd_len = '0;
        req_rsp_len = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        chk("rst_tclk", 64'(tspi_clk), 64'(0));
        chk("rst_new_cmd", 64'(new_cmd), 64'(0));
        chk("rst_en_write", 64'(en_write), 64'(0));
        chk("rst_len_cmd", 64'(len_cmd), 64'(0));
        chk("rst_cmd_data", 64'(cmd_data), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_xfer(32'hA500_0000, 6'd7, 6'd7, 32'h0000_003C, 3, 0);
        run_xfer($urandom, 6'd0, 6'd31, 32'hDEAD_BEEF, 0, 1);
        run_xfer($urandom, 6'd5, 6'd7, $urandom, 1000, 2);
        run_xfer($urandom, 6'd3, 6'd4, $urandom, 2, 10);
        run_xfer($urandom, 6'd31, 6'd0, $urandom, TO - 1, 0);
        run_xfer($urandom, 6'd2, 6'd9, $urandom, TO, 0);

        // Reset in the middle of the command phase, with the clock high
        req_cmd     = $urandom;
        req_cmd_len = 6'd15;
        req_rsp_len = 6'd7;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!tspi_clk && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("mid_cmd_clock_high", 64'(tspi_clk), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tclk", 64'(tspi_clk), 64'(0));
        chk("arst_en_write", 64'(en_write), 64'(0));
        chk("arst_new_cmd", 64'(new_cmd), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_req_ready", 64'(req_ready), 64'(1));
        run_xfer(32'h1234_5678, 6'd11, 6'd15, 32'h0000_C0DE, 5, 1);

        // Randomized transfers
        repeat (14) begin
            cl = 6'($urandom_range(0, 31));
            rl = 6'($urandom_range(0, 31));
            d  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 70))
                                             : int'($urandom_range(0, 8));
            run_xfer($urandom, cl, rl, $urandom, d, int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
